// File: rtl/riscv_ppreg_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush and saturating stall counter. Optional trace fields: `define RISCV_PPREG_TRACE_EN.
module riscv_ppreg_skid #(
  parameter int WIDTH     = 64,
  parameter int CNT_W     = 16,
  parameter int FLUSH_CLR = 1
) (
  input  logic             i_riscv_ppreg_clk,
  input  logic             i_riscv_ppreg_rst,
  input  logic             i_riscv_ppreg_flush,
  input  logic             i_riscv_ppreg_valid,
  output logic             o_riscv_ppreg_ready,
  input  logic [WIDTH-1:0] i_riscv_ppreg_data,
  output logic             o_riscv_ppreg_valid,
  input  logic             i_riscv_ppreg_ready,
  output logic [WIDTH-1:0] o_riscv_ppreg_data,
  input  logic             i_riscv_ppreg_cntclr,
`ifdef RISCV_PPREG_TRACE_EN
  input  logic [63:0]      i_riscv_ppreg_pc,
  input  logic [31:0]      i_riscv_ppreg_inst,
  output logic [63:0]      o_riscv_ppreg_pc,
  output logic [31:0]      o_riscv_ppreg_inst,
`endif
  output logic [CNT_W-1:0] o_riscv_ppreg_stallcnt
);

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_IN,
    SEL_SKID,
    SEL_ZERO
  } sel_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] max_v;
    max_v = '1;
    return (v == max_v) ? v : v + CNT_W'(1);
  endfunction

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic acc, deq;
  sel_e main_sel, skid_sel;

  assign acc = i_riscv_ppreg_valid & ~skid_v_q;
  assign deq = main_v_q & i_riscv_ppreg_ready;

  // Occupancy control: {main_v, skid_v} = 00 EMPTY, 10 BUSY, 11 FULL.
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_sel = SEL_HOLD;
    skid_sel = SEL_HOLD;
    if (i_riscv_ppreg_flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (FLUSH_CLR != 0) begin
        main_sel = SEL_ZERO;
        skid_sel = SEL_ZERO;
      end
    end else begin
      unique case ({main_v_q, skid_v_q})
        2'b00: begin
          if (acc) begin
            main_v_d = 1'b1;
            main_sel = SEL_IN;
          end
        end
        2'b10: begin
          if (acc && deq) begin
            main_sel = SEL_IN;
          end else if (acc) begin
            skid_v_d = 1'b1;
            skid_sel = SEL_IN;
          end else if (deq) begin
            main_v_d = 1'b0;
            main_sel = SEL_ZERO;
          end
        end
        2'b11: begin
          if (deq) begin
            skid_v_d = 1'b0;
            main_sel = SEL_SKID;
          end
        end
        default: begin
          // Skid-only occupancy is unreachable; recover to EMPTY.
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
          main_sel = SEL_ZERO;
          skid_sel = SEL_ZERO;
        end
      endcase
    end
  end

  always_comb begin
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    unique case (main_sel)
      SEL_IN:   main_d_d = i_riscv_ppreg_data;
      SEL_SKID: main_d_d = skid_d_q;
      SEL_ZERO: main_d_d = '0;
      default:  main_d_d = main_d_q;
    endcase
    unique case (skid_sel)
      SEL_IN:   skid_d_d = i_riscv_ppreg_data;
      SEL_ZERO: skid_d_d = '0;
      default:  skid_d_d = skid_d_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_riscv_ppreg_cntclr) begin
      cnt_d = '0;
    end else if (main_v_q && !i_riscv_ppreg_ready && !i_riscv_ppreg_flush) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge i_riscv_ppreg_clk) begin
    if (i_riscv_ppreg_rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= '0;
      skid_d_q <= '0;
      cnt_q    <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef RISCV_PPREG_TRACE_EN
  logic [63:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [31:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;

  // Trace fields follow the payload moves but are always cleared on flush.
  always_comb begin
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (i_riscv_ppreg_flush) begin
      main_pc_d   = '0;
      main_inst_d = '0;
      skid_pc_d   = '0;
      skid_inst_d = '0;
    end else begin
      unique case (main_sel)
        SEL_IN: begin
          main_pc_d   = i_riscv_ppreg_pc;
          main_inst_d = i_riscv_ppreg_inst;
        end
        SEL_SKID: begin
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
        end
        SEL_ZERO: begin
          main_pc_d   = '0;
          main_inst_d = '0;
        end
        default: begin
          main_pc_d   = main_pc_q;
          main_inst_d = main_inst_q;
        end
      endcase
      unique case (skid_sel)
        SEL_IN: begin
          skid_pc_d   = i_riscv_ppreg_pc;
          skid_inst_d = i_riscv_ppreg_inst;
        end
        SEL_ZERO: begin
          skid_pc_d   = '0;
          skid_inst_d = '0;
        end
        default: begin
          skid_pc_d   = skid_pc_q;
          skid_inst_d = skid_inst_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_riscv_ppreg_clk) begin
    if (i_riscv_ppreg_rst) begin
      main_pc_q   <= '0;
      main_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign o_riscv_ppreg_pc   = main_pc_q;
  assign o_riscv_ppreg_inst = main_inst_q;
`endif

  assign o_riscv_ppreg_valid    = main_v_q;
  assign o_riscv_ppreg_data     = main_d_q;
  assign o_riscv_ppreg_ready    = ~skid_v_q;
  assign o_riscv_ppreg_stallcnt = cnt_q;

endmodule

// File: tb/tb_riscv_ppreg_skid.sv
// Bench for riscv_ppreg_skid: directed scenarios then random traffic, checked
// against a queue-based model of the stage (two-deep FIFO plus stall counter).
module tb_riscv_ppreg_skid;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, flush, i_valid, i_ready, cntclr;
  logic [WIDTH-1:0] i_data;
  logic             o_ready, o_valid;
  logic [WIDTH-1:0] o_data;
  logic [CNT_W-1:0] stallcnt;
  logic [63:0]      t_pc;
  logic [31:0]      t_inst;
`ifdef RISCV_PPREG_TRACE_EN
  logic [63:0]      o_pc;
  logic [31:0]      o_inst;
`endif

  riscv_ppreg_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FLUSH_CLR(1)) dut (
    .i_riscv_ppreg_clk     (clk),
    .i_riscv_ppreg_rst     (rst),
    .i_riscv_ppreg_flush   (flush),
    .i_riscv_ppreg_valid   (i_valid),
    .o_riscv_ppreg_ready   (o_ready),
    .i_riscv_ppreg_data    (i_data),
    .o_riscv_ppreg_valid   (o_valid),
    .i_riscv_ppreg_ready   (i_ready),
    .o_riscv_ppreg_data    (o_data),
    .i_riscv_ppreg_cntclr  (cntclr),
`ifdef RISCV_PPREG_TRACE_EN
    .i_riscv_ppreg_pc      (t_pc),
    .i_riscv_ppreg_inst    (t_inst),
    .o_riscv_ppreg_pc      (o_pc),
    .o_riscv_ppreg_inst    (o_inst),
`endif
    .o_riscv_ppreg_stallcnt(stallcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [63:0]      pc;
    logic [31:0]      inst;
  } item_t;

  item_t mq[$];
  int    mcnt;
  int    checks = 0;
  int    passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: the stage is a FIFO of depth two; ready means "fewer than two held".
  task automatic model_edge();
    bit    acc, deq;
    item_t it;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (cntclr) mcnt = 0;
      else if (mq.size() > 0 && !i_ready && !flush && mcnt < MAXC) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        acc = i_valid && (mq.size() < 2);
        deq = (mq.size() > 0) && i_ready;
        if (deq) void'(mq.pop_front());
        if (acc) begin
          it.d = i_data; it.pc = t_pc; it.inst = t_inst;
          mq.push_back(it);
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'(mq.size() > 0));
    chk({tag, ".data"},  64'(o_data),  (mq.size() > 0) ? 64'(mq[0].d) : 64'd0);
    chk({tag, ".ready"}, 64'(o_ready), 64'(mq.size() < 2));
    chk({tag, ".cnt"},   64'(stallcnt), 64'(mcnt));
`ifdef RISCV_PPREG_TRACE_EN
    chk({tag, ".pc"},    o_pc,          (mq.size() > 0) ? mq[0].pc : 64'd0);
    chk({tag, ".inst"},  64'(o_inst),   (mq.size() > 0) ? 64'(mq[0].inst) : 64'd0);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    i_valid = v; i_data = d; i_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cntclr = 1'b0;
    t_pc = '0; t_inst = '0;
    drive(1'b0, '0, 1'b0);
    mq.delete(); mcnt = 0;
    step("reset");
    chk("reset.o_ready", 64'(o_ready), 64'd1);
    chk("reset.o_data", 64'(o_data), 64'd0);
    rst = 1'b0;

    // Streaming at full rate
    drive(1'b1, 16'h1, 1'b1); step("stream1");
    chk("stream1.data", 64'(o_data), 64'h1);
    drive(1'b1, 16'h2, 1'b1); step("stream2");
    chk("stream2.data", 64'(o_data), 64'h2);
    drive(1'b1, 16'h3, 1'b1); step("stream3");
    chk("stream3.data", 64'(o_data), 64'h3);
    drive(1'b0, 16'h0, 1'b1); step("stream_drain");

    // Backpressure into the skid entry
    drive(1'b1, 16'hA, 1'b1); step("bp_a");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hB, 1'b0); step("bp_hold");
    end
    chk("bp.cnt3", 64'(stallcnt), 64'd3);
    chk("bp.ready0", 64'(o_ready), 64'd0);
    chk("bp.holdA", 64'(o_data), 64'hA);
    drive(1'b0, 16'h0, 1'b1); step("bp_outA");
    chk("bp.outB", 64'(o_data), 64'hB);
    step("bp_outB");

    // Flush while FULL with a new item offered
    cntclr = 1'b1; step("clr"); cntclr = 1'b0;
    drive(1'b1, 16'h11, 1'b1); step("fl_fill1");
    drive(1'b1, 16'h22, 1'b0); step("fl_fill2");
    flush = 1'b1; drive(1'b1, 16'hC, 1'b0); step("flush");
    flush = 1'b0;
    chk("flush.valid", 64'(o_valid), 64'd0);
    chk("flush.data", 64'(o_data), 64'd0);
    drive(1'b0, 16'h0, 1'b1); step("flush_after");
    step("flush_after2");

    // Counter saturation and clear-over-increment
    drive(1'b1, 16'h33, 1'b1); step("sat_load");
    drive(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat_stall");
    chk("sat.cnt15", 64'(stallcnt), 64'd15);
    cntclr = 1'b1; step("sat_clr"); cntclr = 1'b0;
    chk("sat.clr0", 64'(stallcnt), 64'd0);

    // Reset while FULL after seven stall cycles
    drive(1'b1, 16'h44, 1'b0);
    for (int i = 0; i < 20 && mcnt < 7; i++) step("rf_fill");
    chk("rf.cnt7", 64'(stallcnt), 64'd7);
    chk("rf.full", 64'(o_ready), 64'd0);
    rst = 1'b1; step("rf_reset"); rst = 1'b0;
    chk("rf.valid0", 64'(o_valid), 64'd0);
    chk("rf.ready1", 64'(o_ready), 64'd1);
    chk("rf.cnt0", 64'(stallcnt), 64'd0);

`ifdef RISCV_PPREG_TRACE_EN
    // Trace fields travel with the payload through the skid entry
    t_pc = 64'h1000; t_inst = 32'h13;
    drive(1'b1, 16'h9, 1'b0); step("tr_first");
    t_pc = 64'h8000_0004; t_inst = 32'h0010_0093;
    drive(1'b1, 16'h5, 1'b0); step("tr_skid");
    drive(1'b0, 16'h0, 1'b1); step("tr_out9");
    chk("tr.data5", 64'(o_data), 64'h5);
    chk("tr.pc", o_pc, 64'h8000_0004);
    chk("tr.inst", 64'(o_inst), 64'h0010_0093);
    drive(1'b0, 16'h0, 1'b0); flush = 1'b1; step("tr_flush"); flush = 1'b0;
    chk("tr.pc0", o_pc, 64'd0);
    chk("tr.inst0", 64'(o_inst), 64'd0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(0, 99) < 60);
      i_ready = ($urandom_range(0, 99) < 55);
      i_data  = WIDTH'($urandom);
      t_pc    = {$urandom, $urandom};
      t_inst  = $urandom;
      flush   = ($urandom_range(0, 99) < 4);
      cntclr  = ($urandom_range(0, 99) < 3);
      rst     = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    rst = 1'b0; flush = 1'b0; cntclr = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
